// File: rtl/d_mem_pkg.sv
// d_mem_pkg: shared types and constants for the d_mem data memory stage.
package d_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  // Wait counter must hold WAIT_CYCLES itself; never narrower than 1 bit.
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/d_mem_if.sv
// d_mem_if: request/response bus between the datapath (master) and d_mem (slave).
// The be lane exists only when DMEM_BYTE_EN_EN is defined.
interface d_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be;
`endif
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] rdata;

  modport master (
`ifdef DMEM_BYTE_EN_EN
    output be,
`endif
    output req, we, addr, wdata,
    input  busy, done, misaligned, rdata
  );

  modport slave (
`ifdef DMEM_BYTE_EN_EN
    input  be,
`endif
    input  req, we, addr, wdata,
    output busy, done, misaligned, rdata
  );
endinterface

// File: rtl/d_mem_wait_counter.sv
// d_mem_wait_counter: loadable down-counter; 'one' flags the final wait cycle.
module d_mem_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             one
);

  logic [WIDTH-1:0] r_cnt;

  // Load has priority over decrement; async clear on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (dec)  r_cnt <= r_cnt - 1'b1;
  end

  assign value = r_cnt;
  assign one   = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/d_mem.sv
// d_mem: word-addressed data memory with request/done handshake and
// WAIT_CYCLES wait states. Optional byte enables under DMEM_BYTE_EN_EN.
module d_mem
  import d_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clock,
  input  logic   reset,
  d_mem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = cnt_width(WAIT_CYCLES);

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic               r_err;
  logic [31:0]        r_rdata;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_accept;
  logic               w_misal;
  logic [3:0]         w_be_in;
  logic               w_cnt_one;
  logic [CNT_W-1:0]   w_cnt_val;

`ifdef DMEM_BYTE_EN_EN
  assign w_be_in = bus.be;
`else
  assign w_be_in = 4'hF;
`endif

  assign w_accept = (r_state == IDLE) && bus.req;
  assign w_misal  = (bus.addr[ADDR_LSB-1:0] != '0);

  d_mem_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (w_accept && !w_misal),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .dec      ((r_state == WAIT) && !w_cnt_one),
    .value    (w_cnt_val),
    .one      (w_cnt_one)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; misaligned requests skip straight to the response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.req) begin
        if (w_misal)               w_next = RESP;
        else if (WAIT_CYCLES == 0) w_next = ACCESS;
        else                       w_next = WAIT;
      end
      WAIT:   if (w_cnt_one) w_next = ACCESS;
      ACCESS: w_next = RESP;
      RESP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decode from the state register only, so no input-to-output path.
  always_comb begin
    bus.busy       = (r_state != IDLE);
    bus.done       = (r_state == RESP);
    bus.misaligned = (r_state == RESP) && r_err;
    bus.rdata      = r_rdata;
  end

  // Request capture on acceptance; error flag cleared by reset so an aborted
  // misaligned request cannot leak into the next response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= bus.addr[IDX_W+ADDR_LSB-1:ADDR_LSB];
      r_we    <= bus.we;
      r_wdata <= bus.wdata;
      r_be    <= w_be_in;
      r_err   <= w_misal;
    end
  end

  // Load data register: only an aligned load in ACCESS updates it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               r_rdata <= '0;
    else if ((r_state == ACCESS) && !r_we)    r_rdata <= r_mem[r_idx];
  end

  // Storage array, not reset; byte lanes gated by the captured enables.
  always_ff @(posedge clock) begin
    if ((r_state == ACCESS) && r_we) begin
      for (int b = 0; b < WORD_BYTES; b++)
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_d_mem.sv
// tb_d_mem: directed self-checking bench for d_mem (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_d_mem;
  logic clock;
  logic reset;

  d_mem_if bus ();

  d_mem #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_idle_done = 0;

  // Global done bookkeeping on the falling edge.
  always @(negedge clock) begin
    if (bus.done === 1'b1) n_done++;
    if (bus.done === 1'b1 && bus.busy !== 1'b1) n_idle_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_in(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
`ifdef DMEM_BYTE_EN_EN
    bus.be    = b;
`else
    if (b == 4'h0) bus.req = r;
`endif
  endtask

  // Issue one request from idle; returns cycles from accept edge to done.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int lat, output logic mis);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.busy !== 1'b0 && n < 20);
    set_in(1'b1, w, a, d, b);
    @(posedge clock);
    #1 bus.req = 1'b0;
    lat = 0;
    mis = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        lat = i;
        mis = bus.misaligned;
        break;
      end
    end
  endtask

  int   lat;
  logic mis;
  int   d0;
  int   first_i, second_i, win_dones;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    set_in(1'b1, 1'b1, 32'h10, 32'h5555_5555, 4'hF);

    // Reset held with req asserted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_mis",  {31'd0, bus.misaligned}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
    end
    bus.req = 1'b0;
    reset = 1'b1;
    d0 = n_done;
    repeat (3) @(negedge clock);
    chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);
    chk("post_rst_nodone", n_done - d0, 0);

    // Store then load.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, mis);
    chk("st_lat", lat, 4);
    chk("st_mis", {31'd0, mis}, 32'd0);
    chk("st_rdata_hold", bus.rdata, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, lat, mis);
    chk("ld_lat", lat, 4);
    chk("ld_rdata", bus.rdata, 32'hDEAD_BEEF);

    // Misaligned store: immediate error response, memory untouched.
    do_req(1'b1, 32'h13, 32'h1234_5678, 4'hF, lat, mis);
    chk("mis_lat", lat, 1);
    chk("mis_flag", {31'd0, mis}, 32'd1);
    chk("mis_rdata_hold", bus.rdata, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, lat, mis);
    chk("mis_ld_rdata", bus.rdata, 32'hDEAD_BEEF);

    // Back-to-back: req held for 10 edges, accepts at edges 1 and 6.
    do @(negedge clock); while (bus.busy !== 1'b0);
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    first_i = 0; second_i = 0; win_dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        win_dones++;
        if (first_i == 0) first_i = i; else second_i = i;
      end
    end
    bus.req = 1'b0;
    d0 = n_done;
    repeat (6) @(negedge clock);
    chk("b2b_dones", win_dones, 2);
    chk("b2b_first", first_i, 4);
    chk("b2b_second", second_i, 9);
    chk("b2b_no_extra", n_done - d0, 0);
    chk("b2b_rdata", bus.rdata, 32'hDEAD_BEEF);

    // Wrap-around: 0x400 aliases word 0.
    do_req(1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, lat, mis);
    do_req(1'b0, 32'h000, 32'h0, 4'hF, lat, mis);
    chk("wrap_lat", lat, 4);
    chk("wrap_rdata", bus.rdata, 32'hCAFE_F00D);

    // Reset mid-operation aborts a pending store.
    do_req(1'b1, 32'h20, 32'h1111_1111, 4'hF, lat, mis);
    do @(negedge clock); while (bus.busy !== 1'b0);
    set_in(1'b1, 1'b1, 32'h20, 32'h2222_2222, 4'hF);
    @(posedge clock);
    #1 bus.req = 1'b0;
    @(negedge clock);
    chk("abort_in_wait", {31'd0, bus.busy}, 32'd1);
    d0 = n_done;
    reset = 1'b0;
    #1 chk("abort_busy_clr", {31'd0, bus.busy}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (8) @(negedge clock);
    chk("abort_nodone", n_done - d0, 0);
    chk("abort_rdata_clr", bus.rdata, 32'd0);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, lat, mis);
    chk("abort_ld", bus.rdata, 32'h1111_1111);

`ifdef DMEM_BYTE_EN_EN
    do_req(1'b1, 32'h0, 32'h0, 4'hF, lat, mis);
    do_req(1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, lat, mis);
    chk("be_st_lat", lat, 4);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, lat, mis);
    chk("be_ld", bus.rdata, 32'h00BB_00DD);
    do_req(1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, lat, mis);
    chk("be0_lat", lat, 4);
    do_req(1'b0, 32'h0, 32'h0, 4'hF, lat, mis);
    chk("be0_ld", bus.rdata, 32'h00BB_00DD);
`endif

    chk("no_done_idle", n_idle_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
